pipeline_sequencer: RTL and testbench

Central run-control and hazard scheduler for the 5-stage MIPS pipeline. It decides, every cycle, whether the pipeline advances, stalls (bubble into ID/EX), flushes IF/ID, or freezes. It supports continuous and single-step execution, and drains the pipeline after a HALT is decoded in ID. It sits between the debug/host interface and the IF, ID, EX, MEM and WB stage enables.

---
 rtl/pipe_seq_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 37 +++
 rtl/pipeline_sequencer.sv | 103 ++++++++++
 tb/tb_pipeline_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_seq_pkg.sv
// Shared encodings for the pipeline run-control sequencer.
// Optional branch/jump-register hazard stalls are enabled with PIPE_SEQ_BRANCH_HAZARD_EN.
package pipe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] REG_IN_JUMP_NONE  = 2'b00;
  localparam logic [1:0] REG_IN_JUMP_RS_RT = 2'b01;
  localparam logic [1:0] REG_IN_JUMP_RS    = 2'b10;

  // HALT decodes as rs=rt=31, so it can collide with a load to r31.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall request: load-use always, branch/jump source use when
// PIPE_SEQ_BRANCH_HAZARD_EN is defined.
module hazard_detect
  import pipe_seq_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] reg_in_jump,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_wr_addr,
  output logic       stall_req
);

  logic match_rs;
  logic match_rt;
  logic load_use;
  logic branch_use;

  assign match_rs = (ex_wr_addr != 5'd0) && (ex_wr_addr == id_rs);
  assign match_rt = (ex_wr_addr != 5'd0) && (ex_wr_addr == id_rt);
  assign load_use = ex_mem_read && (match_rs || match_rt);

`ifdef PIPE_SEQ_BRANCH_HAZARD_EN
  assign branch_use = ex_reg_write &&
                      (((reg_in_jump == REG_IN_JUMP_RS_RT) && (match_rs || match_rt)) ||
                       ((reg_in_jump == REG_IN_JUMP_RS) && match_rs));
`else
  // Jump-register operands are forwarded by the datapath in this build.
  logic unused_jump_fields;
  assign unused_jump_fields = ^{reg_in_jump, ex_reg_write};
  assign branch_use = 1'b0;
`endif

  assign stall_req = load_use || branch_use;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard scheduler for the 5-stage pipeline: run, single-step, HALT drain.
// Optional branch hazard stalls via PIPE_SEQ_BRANCH_HAZARD_EN (applied in hazard_detect).
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_halt_id,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic [1:0]       i_id_reg_in_jump,
  input  logic             i_jump,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_reg_write,
  input  logic [4:0]       i_ex_wr_addr,
  output logic             o_pc_write,
  output logic             o_stall,
  output logic             o_flush_if,
  output logic             o_halt,
  output logic             o_done,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t        state;
  logic          step_latched;
  logic [DW-1:0] drain_cnt;
  logic          adv;
  logic          hazard;
  logic          in_drain;

  hazard_detect u_hazard (
    .id_rs        (i_id_rs),
    .id_rt        (i_id_rt),
    .reg_in_jump  (i_id_reg_in_jump),
    .ex_mem_read  (i_ex_mem_read),
    .ex_reg_write (i_ex_reg_write),
    .ex_wr_addr   (i_ex_wr_addr),
    .stall_req    (hazard)
  );

  always_comb begin
    adv = 1'b0;
    case (state)
      ST_RUN:       adv = 1'b1;
      ST_STEP_WAIT: adv = i_step;
      ST_DRAIN:     adv = !step_latched || i_step;
      default:      adv = 1'b0;
    endcase
  end

  // Draining only pushes NOPs through; no fetch and no bubbles.
  assign in_drain   = (state == ST_DRAIN);
  assign o_stall    = adv && hazard && !in_drain;
  assign o_pc_write = adv && !o_stall && !in_drain;
  assign o_flush_if = in_drain ? adv : (adv && i_jump && !o_stall);
  assign o_halt     = !adv;
  assign o_done     = (state == ST_DONE);
  assign o_state    = state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      step_latched  <= 1'b0;
      drain_cnt     <= '0;
      o_cycle_count <= '0;
    end else begin
      if (adv && (o_cycle_count != {CNT_W{1'b1}}))
        o_cycle_count <= o_cycle_count + 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            step_latched <= i_step_mode;
            state        <= i_step_mode ? ST_STEP_WAIT : ST_RUN;
          end
        end
        ST_RUN, ST_STEP_WAIT: begin
          if (adv && i_halt_id && !o_stall) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (adv) begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == DW'(1))
              state <= ST_DONE;
          end
        end
        default: state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed vector table plus randomized run against a spec-level reference model.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, step_mode, step, halt_id, jump, mem_read, reg_write;
  logic [4:0]  rs, rt, wr;
  logic [1:0]  rij;
  logic        pc_write, stall, flush_if, halt, done;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start),
    .i_step_mode      (step_mode),
    .i_step           (step),
    .i_halt_id        (halt_id),
    .i_id_rs          (rs),
    .i_id_rt          (rt),
    .i_id_reg_in_jump (rij),
    .i_jump           (jump),
    .i_ex_mem_read    (mem_read),
    .i_ex_reg_write   (reg_write),
    .i_ex_wr_addr     (wr),
    .o_pc_write       (pc_write),
    .o_stall          (stall),
    .o_flush_if       (flush_if),
    .o_halt           (halt),
    .o_done           (done),
    .o_state          (state),
    .o_cycle_count    (cycle_count)
  );

  wire [4:0] flags = {stall, pc_write, flush_if, halt, done};

  typedef struct {
    logic       start, mode, step, halt_id;
    logic [4:0] rs, rt, wr;
    logic [1:0] rij;
    logic       jump, mr, rw;
    logic [4:0] exp_flags;   // {stall, pc_write, flush_if, halt, done}
    logic [2:0] exp_state;
    int         exp_cnt;
  } vec_t;

  function automatic vec_t mkv(logic st, logic md, logic sp, logic hl,
                               logic [4:0] a, logic [4:0] b, logic [4:0] w,
                               logic [1:0] j2, logic jp, logic mr, logic rw,
                               logic [4:0] f, logic [2:0] s, int c);
    vec_t v;
    v.start = st; v.mode = md; v.step = sp; v.halt_id = hl;
    v.rs = a; v.rt = b; v.wr = w; v.rij = j2;
    v.jump = jp; v.mr = mr; v.rw = rw;
    v.exp_flags = f; v.exp_state = s; v.exp_cnt = c;
    return v;
  endfunction

  function automatic vec_t zv();
    return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic set_in(input vec_t v);
    start = v.start; step_mode = v.mode; step = v.step; halt_id = v.halt_id;
    rs = v.rs; rt = v.rt; wr = v.wr; rij = v.rij;
    jump = v.jump; mem_read = v.mr; reg_write = v.rw;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(zv());
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: state held as plain integers, rules taken directly from the behaviour list.
  int          m_st;
  bit          m_sl;
  int          m_left;
  longint      m_cnt;
  bit          e_adv, e_stall, e_pcw, e_flush;

  function automatic bit ref_hazard();
    bit lu, br;
    lu = mem_read && wr != 0 && (wr == rs || wr == rt);
    br = 1'b0;
`ifdef PIPE_SEQ_BRANCH_HAZARD_EN
    if (reg_write && wr != 0) begin
      if (rij == 2'b01) br = (wr == rs || wr == rt);
      if (rij == 2'b10) br = (wr == rs);
    end
`endif
    return lu || br;
  endfunction

  task automatic ref_outputs();
    e_adv   = (m_st == 1) || (m_st == 2 && step) || (m_st == 3 && (!m_sl || step));
    e_stall = e_adv && m_st != 3 && ref_hazard();
    e_pcw   = e_adv && m_st != 3 && !e_stall;
    e_flush = (m_st == 3) ? e_adv : (e_adv && jump && !e_stall);
  endtask

  task automatic ref_clock();
    if (rst) begin
      m_st = 0; m_sl = 0; m_left = 0; m_cnt = 0;
    end else begin
      if (e_adv && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_st == 0 && start) begin
        m_sl = step_mode;
        m_st = step_mode ? 2 : 1;
      end else if ((m_st == 1 || m_st == 2) && e_adv && halt_id && !e_stall) begin
        m_st = 3;
        m_left = 4;
      end else if (m_st == 3 && e_adv) begin
        m_left--;
        if (m_left == 0) m_st = 4;
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst = 1'b0;
    set_in(zv());
    @(negedge clk);
    do_reset();

    //         st md sp hl rs  rt  wr  rij jp mr rw  flags     st cnt
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b01000, 1, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, 5'b01000, 1, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 5,  0,  5,  0, 0, 1, 0, 5'b10000, 1, 2));
    tbl.push_back(mkv(0, 0, 0, 0, 0,  7,  7,  0, 1, 1, 0, 5'b10000, 1, 3));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0,  0,  0, 0, 1, 0, 5'b01000, 1, 4));
    tbl.push_back(mkv(0, 0, 0, 0, 3,  4,  0,  0, 1, 0, 0, 5'b01100, 1, 5));
    tbl.push_back(mkv(0, 0, 0, 1, 31, 31, 31, 0, 0, 1, 0, 5'b10000, 1, 6));
    tbl.push_back(mkv(0, 0, 0, 1, 31, 31, 31, 0, 0, 0, 1, 5'b01000, 1, 7));
    tbl.push_back(mkv(0, 0, 0, 0, 5,  0,  5,  0, 0, 1, 0, 5'b00100, 3, 8));
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0, 1, 0, 0, 5'b00100, 3, 9));
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b00100, 3, 10));
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b00100, 3, 11));
    tbl.push_back(mkv(1, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b00011, 4, 12));
    tbl.push_back(mkv(0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 5'b00011, 4, 12));

    foreach (tbl[i]) begin
      set_in(tbl[i]);
      #2;
      chk($sformatf("vec%0d_flags", i), 64'(flags), 64'(tbl[i].exp_flags));
      chk($sformatf("vec%0d_state", i), 64'(state), 64'(tbl[i].exp_state));
      chk($sformatf("vec%0d_count", i), 64'(cycle_count), 64'(tbl[i].exp_cnt));
      tick();
    end

    // Single-step: halted between pulses, one count per pulse, then a stepped drain.
    do_reset();
    v = zv(); v.start = 1; v.mode = 1; set_in(v);
    tick();
    set_in(zv());
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("step_wait_state", 64'(state), 64'd2);
      chk("step_wait_halt", 64'(halt), 64'd1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; #2;
      chk("step_pulse_flags", 64'(flags), 64'b01000);
      tick();
      step = 1'b0; #2;
      chk("step_gap_flags", 64'(flags), 64'b00010);
      tick();
    end
    chk("step_count", 64'(cycle_count), 64'd3);
    step = 1'b1; halt_id = 1'b1;
    tick();
    set_in(zv()); #2;
    chk("step_drain_hold", 64'(flags), 64'b00010);
    chk("step_drain_state", 64'(state), 64'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      step = 1'b1; #2;
      chk("step_drain_pulse", 64'(flags), 64'b00100);
      tick();
      step = 1'b0; tick();
    end
    chk("step_drain_done", 64'({state, done}), 64'({3'd4, 1'b1}));

    // Jump-register hazard, present only in the optional build.
    do_reset();
    v = zv(); v.start = 1; set_in(v);
    tick();
    v = zv(); v.rij = 2'b10; v.rw = 1; v.wr = 8; v.rs = 8; v.jump = 1; set_in(v);
    #2;
`ifdef PIPE_SEQ_BRANCH_HAZARD_EN
    chk("br_rs_flags", 64'(flags), 64'b10000);
`else
    chk("br_rs_flags", 64'(flags), 64'b01100);
`endif
    tick();
    v.rs = 0; v.rt = 8; set_in(v); #2;
    chk("br_rs_only_ignores_rt", 64'(flags), 64'b01100);
    tick();
    v.rij = 2'b01; set_in(v); #2;
`ifdef PIPE_SEQ_BRANCH_HAZARD_EN
    chk("br_rsrt_flags", 64'(flags), 64'b10000);
`else
    chk("br_rsrt_flags", 64'(flags), 64'b01100);
`endif
    tick();

    // Reset mid-run returns to IDLE with counter cleared.
    set_in(zv());
    rst = 1'b1; tick(); rst = 1'b0; #2;
    chk("midrun_reset", 64'({state, cycle_count}), 64'({3'd0, 32'd0}));
    chk("midrun_reset_flags", 64'(flags), 64'b00010);

    // Randomized run against the reference model.
    m_st = 0; m_sl = 0; m_left = 0; m_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      start     = ($urandom_range(0, 5) == 0);
      step_mode = $urandom_range(0, 1) == 1;
      step      = ($urandom_range(0, 2) == 0);
      halt_id   = ($urandom_range(0, 15) == 0);
      rs        = 5'($urandom_range(0, 3));
      rt        = 5'($urandom_range(0, 3));
      wr        = 5'($urandom_range(0, 3));
      rij       = 2'($urandom_range(0, 2));
      jump      = $urandom_range(0, 1) == 1;
      mem_read  = $urandom_range(0, 1) == 1;
      reg_write = $urandom_range(0, 1) == 1;
      #2;
      ref_outputs();
      chk("rand_outputs", 64'({state, flags}),
          64'({3'(m_st), e_stall, e_pcw, e_flush, !e_adv, m_st == 4}));
      chk("rand_count", 64'(cycle_count), 64'(m_cnt));
      @(posedge clk);
      ref_clock();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
